// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: word type, RAM handshake state and the arbiter FSM
// encoding, so that later masters (e.g. a coherence controller) reuse them.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/memory_arbiter.sv
// Serializes icache/dcache word accesses onto the single-ported RAM with a
// registered grant FSM, data-first priority and an instruction starvation guard.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate
);

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  arb_state_t    state_q, state_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          dreq;
  logic          ram_done;

  assign dreq     = dREN | dWEN;
  // A completion coinciding with reset is abandoned rather than reported.
  assign ram_done = (ramstate == ACCESS) && !RST;

  // Read data is shared; each cache qualifies it with its own wait.
  assign iload = ramload;
  assign dload = ramload;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ARB;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    iwait    = 1'b1;
    dwait    = 1'b1;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;

    unique case (state_q)
      ARB: begin
        if (dreq && iREN && (starve_q == LIMIT)) begin
          state_d = IGRANT;
        end else if (dreq) begin
          state_d = DGRANT;
        end else if (iREN) begin
          state_d = IGRANT;
        end
        if (!iREN) begin
          starve_d = '0;
        end
      end

      DGRANT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        if (!dreq) begin
          state_d = ARB;
        end else if (ram_done) begin
          state_d = ARB;
          dwait   = 1'b0;
          if (iREN && (starve_q != LIMIT)) begin
            starve_d = starve_q + CW'(1);
          end
        end
      end

      IGRANT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        if (!iREN) begin
          state_d = ARB;
        end else if (ram_done) begin
          state_d  = ARB;
          iwait    = 1'b0;
          starve_d = '0;
        end
      end

      default: state_d = ARB;
    endcase
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: stimulus pushes expected completions,
// a negedge monitor pops and checks them when a wait goes low.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  localparam int LIMIT = 4;

  logic      CLK = 1'b0;
  logic      RST;
  logic      iREN, dREN, dWEN;
  word_t     iaddr, daddr, dstore, ramload;
  logic      iwait, dwait, ramREN, ramWEN;
  word_t     iload, dload, ramaddr, ramstore;
  ramstate_t ramstate;

  always #5 CLK = ~CLK;

  memory_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  typedef struct {
    logic  is_d;
    int    cyc;
    word_t addr;
    word_t store;
    logic  chk_store;
    logic  ren;
    logic  wen;
    word_t data;
  } exp_t;

  exp_t sb[$];
  int   nvec = 0;
  int   nmis = 0;
  int   cyc  = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every wait-low cycle must match the oldest expected completion.
  always @(negedge CLK) begin
    exp_t e;
    if (!iwait || !dwait) begin
      if (sb.size() == 0) begin
        chk("unexpected_completion", {30'b0, iwait, dwait}, 32'h3);
      end else begin
        e = sb.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("dwait", {31'b0, dwait}, {31'b0, !e.is_d});
        chk("iwait", {31'b0, iwait}, {31'b0, e.is_d});
        chk("ramaddr", ramaddr, e.addr);
        chk("ramREN", {31'b0, ramREN}, {31'b0, e.ren});
        chk("ramWEN", {31'b0, ramWEN}, {31'b0, e.wen});
        if (e.chk_store) chk("ramstore", ramstore, e.store);
        chk("load", e.is_d ? dload : iload, e.data);
      end
    end else if (sb.size() != 0 && sb[0].cyc < cyc) begin
      chk("missed_completion", cyc, sb[0].cyc);
      void'(sb.pop_front());
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic at_neg();
    @(negedge CLK);
  endtask

  task automatic expect_done(input logic is_d, input word_t addr, input word_t store,
                             input logic cs, input logic ren, input logic wen,
                             input word_t data);
    exp_t e;
    e = '{is_d, cyc, addr, store, cs, ren, wen, data};
    sb.push_back(e);
  endtask

  // Both caches requesting, RAM answering ACCESS at once; called in an ARB cycle.
  task automatic run_grants(input int n, input int s0);
    int s;
    s = s0;
    for (int k = 0; k < n; k++) begin
      step();
      if (s == LIMIT) begin
        expect_done(1'b0, iaddr, '0, 1'b0, 1'b1, 1'b0, ramload);
        s = 0;
      end else begin
        expect_done(1'b1, daddr, dstore, 1'b1, 1'b1, 1'b0, ramload);
        s = s + 1;
      end
      step();
      at_neg();
      chk("bubble_ramREN", {31'b0, ramREN}, 32'h0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
    step(); step();
    at_neg();
    chk("rst_iwait", {31'b0, iwait}, 32'h1);
    chk("rst_dwait", {31'b0, dwait}, 32'h1);
    chk("rst_ramREN", {31'b0, ramREN}, 32'h0);
    chk("rst_ramWEN", {31'b0, ramWEN}, 32'h0);
    chk("rst_ramaddr", ramaddr, 32'h0);
    chk("rst_ramstore", ramstore, 32'h0);
    step();
    RST = 1'b0;

    // dcache read with two BUSY cycles
    dREN = 1'b1; daddr = 32'h0000_0040;
    step();
    ramstate = BUSY;
    at_neg();
    chk("dread_ramREN", {31'b0, ramREN}, 32'h1);
    chk("dread_ramaddr", ramaddr, 32'h40);
    chk("dread_dwait_busy", {31'b0, dwait}, 32'h1);
    step();
    step();
    ramstate = ACCESS; ramload = 32'hDEAD_BEEF;
    expect_done(1'b1, 32'h40, 32'h0, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF);
    step();
    dREN = 1'b0; ramstate = FREE;
    at_neg();
    chk("dread_after_dwait", {31'b0, dwait}, 32'h1);

    // dcache write: write wins over read
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h3100; dstore = 32'h7;
    ramstate = ACCESS; ramload = 32'h55;
    step();
    expect_done(1'b1, 32'h3100, 32'h7, 1'b1, 1'b0, 1'b1, 32'h55);
    step();
    dREN = 1'b0; dWEN = 1'b0;
    at_neg();
    chk("dwrite_one_cycle", {31'b0, dwait}, 32'h1);

    // contention: D,D,D,D,I,D,D,D,D,I
    ramstate = ACCESS; ramload = 32'h1234_5678;
    daddr = 32'h100; dstore = 32'hA5; iaddr = 32'h200;
    dREN = 1'b1; iREN = 1'b1;
    run_grants(10, 0);

    // reset mid-grant clears the starve count
    run_grants(2, 0);
    ramstate = BUSY;
    step();
    at_neg();
    chk("pre_rst_ramREN", {31'b0, ramREN}, 32'h1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    at_neg();
    chk("post_rst_ramREN", {31'b0, ramREN}, 32'h0);
    chk("post_rst_ramWEN", {31'b0, ramWEN}, 32'h0);
    chk("post_rst_dwait", {31'b0, dwait}, 32'h1);
    ramstate = ACCESS;
    run_grants(5, 0);
    dREN = 1'b0; iREN = 1'b0; ramstate = FREE;
    step();

    // ERROR retry on the icache
    iREN = 1'b1; iaddr = 32'h80; ramstate = ERROR;
    for (int k = 0; k < 3; k++) begin
      step();
      at_neg();
      chk("err_ramREN", {31'b0, ramREN}, 32'h1);
      chk("err_iwait", {31'b0, iwait}, 32'h1);
      chk("err_ramaddr", ramaddr, 32'h80);
    end
    step();
    ramstate = ACCESS; ramload = 32'hCAFE_F00D;
    expect_done(1'b0, 32'h80, 32'h0, 1'b0, 1'b1, 1'b0, 32'hCAFE_F00D);
    step();
    iREN = 1'b0; ramstate = FREE;
    at_neg();
    chk("err_after_iwait", {31'b0, iwait}, 32'h1);

    // icache withdrawal before ACCESS, then a dcache request right behind it
    iREN = 1'b1; iaddr = 32'h300; ramstate = BUSY;
    step();
    at_neg();
    chk("wd_ramREN", {31'b0, ramREN}, 32'h1);
    #1;
    iREN = 1'b0; ramstate = ACCESS; ramload = 32'h77;
    dREN = 1'b1; daddr = 32'h44; dstore = 32'h0;
    step();
    at_neg();
    chk("wd_arb_ramREN", {31'b0, ramREN}, 32'h0);
    chk("wd_arb_iwait", {31'b0, iwait}, 32'h1);
    step();
    expect_done(1'b1, 32'h44, 32'h0, 1'b1, 1'b1, 1'b0, 32'h77);
    step();
    dREN = 1'b0; ramstate = FREE;
    step();
    step();
    at_neg();
    chk("scoreboard_empty", sb.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
